// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage.
// Holds the I/O page register offsets and the TXSTAT bit layout.
package dmem_mmio_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] TXSTAT_OFF = 32'd4;
  localparam logic [31:0] CYCLE_OFF  = 32'd8;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int OVF_BIT   = 2;
  localparam int COUNT_LSB = 8;

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO without bypass.
// Ports:
//   clk, reset      clock and synchronous active-high reset (control only)
//   push, din       write request and data
//   pop             read request (ignored when empty)
//   dout            head entry
//   count           occupancy, log2(DEPTH)+1 bits
//   full, empty     occupancy flags
//   push_ok         push accepted this cycle (not full, or popping alongside)
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory stage with a word RAM and an MMIO page.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   addr, write_data     byte address and store data from the MEM stage
//   mem_write            store strobe, applied at the rising edge
//   readdata             combinational load data
//   tx_data, tx_valid    TX FIFO head and non-empty flag
//   tx_ready             downstream accepts tx_data this cycle
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] readdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          hit_txdata;
  logic          hit_txstat;
  logic          hit_cycle;
  logic          unused_low_bits;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_push_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   cycle;
  logic [31:0]   stat_word;

  // Byte offset bits are ignored: every access is a whole word.
  assign unused_low_bits = ^addr[1:0];
  assign word_addr  = {addr[31:2], 2'b00};
  assign ram_hit    = ({2'b00, addr[31:2]} < 32'(RAM_WORDS));
  assign ram_idx    = addr[AW+1:2];
  assign hit_txdata = (word_addr == IO_BASE + TXDATA_OFF);
  assign hit_txstat = (word_addr == IO_BASE + TXSTAT_OFF);
  assign hit_cycle  = (word_addr == IO_BASE + CYCLE_OFF);

  always_ff @(posedge clk) begin
    if (mem_write && ram_hit) begin
      ram[ram_idx] <= write_data;
    end
  end

  assign fifo_push = mem_write && hit_txdata;
  // No transfer is allowed on a reset edge, so the pop is masked here.
  assign fifo_pop  = tx_valid && tx_ready && !reset;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (write_data),
    .dout    (tx_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (fifo_push_ok)
  );

  assign tx_valid = !fifo_empty;

  assign ovf_set = fifo_push && !fifo_push_ok;
  assign ovf_clr = mem_write && hit_txstat && write_data[OVF_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
    end else if (mem_write && hit_cycle) begin
      cycle <= write_data;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // While reset is held, I/O reads show the state the reset edge will leave.
  always_comb begin
    stat_word = '0;
    if (reset) begin
      stat_word[EMPTY_BIT] = 1'b1;
    end else begin
      stat_word[EMPTY_BIT]            = fifo_empty;
      stat_word[FULL_BIT]             = fifo_full;
      stat_word[OVF_BIT]              = ovf;
      stat_word[COUNT_LSB +: 8]       = 8'(fifo_count);
    end
  end

  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = ram[ram_idx];
    end else if (hit_txstat) begin
      readdata = stat_word;
    end else if (hit_cycle) begin
      readdata = reset ? 32'd0 : cycle;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio.
module tb_dmem_mmio;

  localparam logic [31:0] IOB    = 32'hFFFF0000;
  localparam logic [31:0] TXDATA = IOB + 32'd0;
  localparam logic [31:0] TXSTAT = IOB + 32'd4;
  localparam logic [31:0] CYCLE  = IOB + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] readdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  dmem_mmio #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (4),
    .IO_BASE    (IOB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .mem_write  (mem_write),
    .readdata   (readdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    addr       = '0;
    write_data = '0;
    mem_write  = 1'b0;
    tx_ready   = 1'b0;
    tick();
    rd_check("stat_in_reset", TXSTAT, 32'h1);
    tick();
    reset = 1'b0;
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    rd_check("reset_stat", TXSTAT, 32'h1);

    // RAM store / load and decode
    wr(32'h10, 32'hDEADBEEF);
    rd_check("ram_0x10", 32'h10, 32'hDEADBEEF);
    rd_check("ram_0x13", 32'h13, 32'hDEADBEEF);
    rd_check("ram_oor", 32'h1000, 32'h0);
    rd_check("txdata_read", TXDATA, 32'h0);
    rd_check("io_unmapped", IOB + 32'd12, 32'h0);

    // same-cycle read of the word being written returns the old value
    addr = 32'h10; write_data = 32'h12345678; mem_write = 1'b1;
    #1;
    check("ram_old_on_write", readdata, 32'hDEADBEEF);
    @(posedge clk); #1; mem_write = 1'b0;
    rd_check("ram_new", 32'h10, 32'h12345678);
    wr(32'h10, 32'hDEADBEEF);

    // fill with tx_ready low, then overflow
    wr(TXDATA, 32'd1);
    check("push_empty_valid", {31'd0, tx_valid}, 32'd1);
    check("push_empty_data", tx_data, 32'd1);
    wr(TXDATA, 32'd2);
    wr(TXDATA, 32'd3);
    wr(TXDATA, 32'd4);
    rd_check("stat_full", TXSTAT, 32'h402);
    wr(TXDATA, 32'd5);
    rd_check("stat_ovf", TXSTAT, 32'h406);
    wr(TXSTAT, 32'd4);
    rd_check("stat_ovf_clr", TXSTAT, 32'h402);

    // drain
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_data%0d", k), tx_data, 32'(k));
      check($sformatf("drain_valid%0d", k), {31'd0, tx_valid}, 32'd1);
      tick();
    end
    check("drained_valid", {31'd0, tx_valid}, 32'd0);
    rd_check("drained_stat", TXSTAT, 32'h1);

    // full FIFO, push together with pop
    tx_ready = 1'b0;
    wr(TXDATA, 32'd5);
    wr(TXDATA, 32'd6);
    wr(TXDATA, 32'd7);
    wr(TXDATA, 32'd8);
    rd_check("refill_full", TXSTAT, 32'h402);
    tx_ready = 1'b1;
    wr(TXDATA, 32'd9);
    rd_check("pushpop_stat", TXSTAT, 32'h402);
    for (int k = 6; k <= 9; k++) begin
      check($sformatf("pp_data%0d", k), tx_data, 32'(k));
      tick();
    end
    check("pp_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // cycle counter load and wrap
    wr(CYCLE, 32'hFFFFFFFE);
    rd_check("cycle_load", CYCLE, 32'hFFFFFFFE);
    tick();
    rd_check("cycle_inc", CYCLE, 32'hFFFFFFFF);
    tick();
    rd_check("cycle_wrap", CYCLE, 32'h0);

    // reset with data queued
    wr(TXDATA, 32'hA);
    wr(TXDATA, 32'hB);
    wr(TXDATA, 32'hC);
    rd_check("three_queued", TXSTAT, 32'h300);
    reset = 1'b1;
    rd_check("cycle_in_reset", CYCLE, 32'h0);
    tick();
    reset = 1'b0;
    check("post_reset_valid", {31'd0, tx_valid}, 32'd0);
    rd_check("post_reset_stat", TXSTAT, 32'h1);
    rd_check("post_reset_cycle", CYCLE, 32'h0);
    rd_check("post_reset_ram", 32'h10, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
